// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - XLEN          : datapath width of addresses and data.
//   - WIDTH_*       : encodings of the access-width field (byte/half/word).
//   - arb_state_t   : arbiter states (idle, fetch in flight, data in flight).
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_checker.sv
// ---------------------------------------------------------------------------
// mem_arbiter_checker
// Simulation-only protocol checks for mem_arbiter. Instantiate it next to the
// arbiter and connect it to the same nets. It contains no logic of its own.
// Ports:
//   clk, reset      : clock and synchronous active-high reset of the arbiter.
//   busy            : arbiter has a memory transaction in flight.
//   m_ack           : memory completion pulse.
//   i_ack, d_ack    : completion pulses towards fetch and memory stage.
// ---------------------------------------------------------------------------
module mem_arbiter_checker (
  input logic clk,
  input logic reset,
  input logic busy,
  input logic m_ack,
  input logic i_ack,
  input logic d_ack
);

  // The memory may only complete a request the arbiter actually issued.
  a_no_idle_ack: assert property (@(posedge clk) disable iff (reset) !(m_ack && !busy))
    else $error("FAIL m_ack_in_idle: m_ack=1 while arbiter idle");

  // At most one requester is completed per memory transaction.
  a_one_ack: assert property (@(posedge clk) disable iff (reset) !(i_ack && d_ack))
    else $error("FAIL dual_ack: i_ack and d_ack both 1");

  // An ack towards a requester only ever accompanies a memory ack.
  a_ack_needs_mem: assert property (@(posedge clk) disable iff (reset) !((i_ack || d_ack) && !m_ack))
    else $error("FAIL ack_without_m_ack: requester ack without m_ack");

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the instruction-fetch requester (I) and the
// memory-stage data requester (D). Each side keeps its own req/ack handshake.
// D wins contention by default; after STARVE_LIMIT consecutive lost
// arbitrations by a pending I request, I is forced to win.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset.
//   i_req, i_addr                      : fetch read request (held until i_ack).
//   i_ack, i_data                      : fetch completion pulse and read data.
//   d_req, d_addr, d_write, d_wdata,
//   d_extend, d_width                  : data request (held until d_ack).
//   d_ack, d_rdata                     : data completion pulse and load data.
//   m_req, m_addr, m_write, m_wdata,
//   m_extend, m_width                  : registered request to memory.
//   m_ack, m_rdata                     : memory completion pulse and read data.
//   busy                               : a transaction is in flight.
//   grant_d                            : the in-flight transaction belongs to D.
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_data,
  input  logic            d_req,
  input  logic [XLEN-1:0] d_addr,
  input  logic            d_write,
  input  logic [XLEN-1:0] d_wdata,
  input  logic            d_extend,
  input  logic [1:0]      d_width,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic [XLEN-1:0] m_addr,
  output logic            m_write,
  output logic [XLEN-1:0] m_wdata,
  output logic            m_extend,
  output logic [1:0]      m_width,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata,
  output logic            busy,
  output logic            grant_d
);

  localparam int              CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic             aborted;
  logic             pick_i;
  logic             pick_d;
  logic             owner_req;

  // Arbitration: only meaningful in IDLE; D wins unless I has starved long enough.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && (!d_req || (starve_cnt == LIMIT_CNT))) begin
        pick_i = 1'b1;
      end else if (d_req) begin
        pick_d = 1'b1;
      end else begin
        pick_i = 1'b0;
        pick_d = 1'b0;
      end
    end else begin
      pick_i = 1'b0;
      pick_d = 1'b0;
    end
  end

  // Request line of whichever side owns the in-flight transaction (abort watch).
  always_comb begin
    owner_req = 1'b0;
    case (state)
      BUSY_I:  owner_req = i_req;
      BUSY_D:  owner_req = d_req;
      default: owner_req = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a transaction always runs to m_ack, then returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_i) begin
          state_next = BUSY_I;
        end else if (pick_d) begin
          state_next = BUSY_D;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ack) begin
          state_next = IDLE;
        end else begin
          state_next = state;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: acks are combinational from m_ack, status flags come from the state register.
  always_comb begin
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    busy    = (state != IDLE);
    grant_d = (state == BUSY_D);
    // An aborted transaction completes silently; reset suppresses a late ack.
    if (!reset && m_ack && owner_req && !aborted) begin
      i_ack = (state == BUSY_I);
      d_ack = (state == BUSY_D);
    end else begin
      i_ack = 1'b0;
      d_ack = 1'b0;
    end
  end

  // Read data is shared; only the matching ack qualifies it.
  assign i_data  = m_rdata;
  assign d_rdata = m_rdata;

  // Memory-side request latch: loaded at grant, held stable until m_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_req    <= 1'b0;
      m_addr   <= {XLEN{1'b0}};
      m_write  <= 1'b0;
      m_wdata  <= {XLEN{1'b0}};
      m_extend <= 1'b0;
      m_width  <= WIDTH_BYTE;
    end else if (pick_i) begin
      m_req    <= 1'b1;
      m_addr   <= i_addr;
      m_write  <= 1'b0;
      m_wdata  <= {XLEN{1'b0}};
      m_extend <= 1'b0;
      m_width  <= WIDTH_WORD;
    end else if (pick_d) begin
      m_req    <= 1'b1;
      m_addr   <= d_addr;
      m_write  <= d_write;
      m_wdata  <= d_wdata;
      m_extend <= d_extend;
      m_width  <= d_width;
    end else if (busy && m_ack) begin
      m_req    <= 1'b0;
    end else begin
      m_req    <= m_req;
    end
  end

  // Abort flag: sticky once the owner drops its request, cleared on return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      aborted <= 1'b0;
    end else if ((state == IDLE) || m_ack) begin
      aborted <= 1'b0;
    end else if (!owner_req) begin
      aborted <= 1'b1;
    end else begin
      aborted <= aborted;
    end
  end

  // Starvation counter: counts IDLE cycles where a pending fetch loses to D.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= {CNT_W{1'b0}};
    end else if (state == IDLE) begin
      if (!i_req || pick_i) begin
        starve_cnt <= {CNT_W{1'b0}};
      end else if (pick_d && (starve_cnt != LIMIT_CNT)) begin
        starve_cnt <= starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        starve_cnt <= starve_cnt;
      end
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (I) and the memory-stage data requester (D).
- Each side keeps the same req/ack handshake it would use with a dedicated memory.
- Data requests win by default; a starvation counter guarantees fetch progress.
- Placement: between the fetch stage, the memory stage and the memory/bus interface.

Parameters:
- STARVE_LIMIT, 4: number of consecutive lost arbitrations by a pending I request before I is forced to win.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- i_req  in  1  fetch read request; held until i_ack.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle completion pulse to fetch.
- i_data  out  32  read data; valid only while i_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_addr  in  32  data address.
- d_write  in  1  1=store, 0=load.
- d_wdata  in  32  store data.
- d_extend  in  1  sign-extend load.
- d_width  in  2  00=byte, 01=half, 10=word.
- d_ack  out  1  one-cycle completion pulse to the memory stage.
- d_rdata  out  32  load data; valid only while d_ack=1.
- m_req  out  1  request to memory.
- m_addr  out  32  memory address.
- m_write  out  1  memory write enable.
- m_wdata  out  32  memory write data.
- m_extend  out  1  sign-extend.
- m_width  out  2  access width.
- m_ack  in  1  memory completion pulse.
- m_rdata  in  32  memory read data, valid with m_ack.
- busy  out  1  transaction in flight (state != IDLE).
- grant_d  out  1  in-flight transaction belongs to D.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset:
  - state=IDLE; m_req=0; m_addr, m_wdata=0; m_write=0; m_extend=0; m_width=00.
  - i_ack=0, d_ack=0, busy=0, grant_d=0, aborted=0, starve_cnt=0.
- IDLE arbitration, decided in cycle T:
  - Only d_req: choose D.
  - Only i_req: choose I.
  - Both: choose I if starve_cnt==STARVE_LIMIT, else choose D.
  - Chosen request fields are latched into output registers; state moves to BUSY_x at T+1, and m_req=1 from T+1.
  - I transaction drives m_write=0, m_width=10, m_extend=0, m_wdata=0.
- Starve counter (saturating, width $clog2(STARVE_LIMIT+1)):
  - Increments in each IDLE cycle where i_req=1 and D is chosen.
  - Cleared when I is granted, or when in IDLE with i_req=0.
  - Holds its value while in BUSY states.
- BUSY_x:
  - m_req and all latched m_* fields are held stable until m_ack.
  - Requester inputs are ignored except x_req, which is monitored for abort.
- Completion (m_ack=1 in BUSY_x):
  - If x_req=1 and aborted=0: x_ack=1 combinationally in that same cycle, and x_data/d_rdata = m_rdata.
  - Next state is IDLE and m_req=0.
  - x_ack is never asserted outside a cycle with m_ack.
- Latency:
  - Minimum request-to-ack is 2 cycles (req sampled at T, m_ack at T+1).
  - At least one IDLE cycle separates transactions, so a requester's next request is sampled in the cycle after its ack.
- Abort:
  - If the granted requester drops x_req while in BUSY (e.g. fetch redirect, pipeline flush), set aborted=1.
  - The memory transaction still runs to m_ack, because memory requests cannot be withdrawn.
  - No x_ack is issued and m_rdata is discarded.
  - aborted clears on return to IDLE.
  - If x_req is re-raised before m_ack, it is still treated as aborted; the new request is arbitrated afresh from IDLE.
- Simultaneous events:
  - i_ack and d_ack are never both 1.
  - m_ack while in IDLE is ignored and flagged by a simulation-only assertion.
  - An ungranted requester's req has no effect during BUSY.
- Reset during BUSY:
  - Transaction abandoned; m_req=0 in the cycle after reset is sampled, and no ack is issued.
  - The memory side must tolerate the withdrawn request.
- Output mux: i_data and d_rdata are both wired to m_rdata; only the ack qualifies them.

Decomposition:
- Shared package mem_pkg holds:
  - state enum arb_state_t {IDLE, BUSY_I, BUSY_D};
  - width constants WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10;
  - XLEN=32.
- No sub-module. The starve counter and output latch are a few lines each and stay inline.

Test Plan:
- Lone fetch: i_req=1, addr 0x100; memory acks one cycle after m_req with 0xDEADBEEF -> m_req at T+1, m_addr=0x100, m_width=10, i_ack pulses at T+2 with i_data=0xDEADBEEF, d_ack stays 0.
- Contention: i_req and d_req both high, d store to 0x2000 width 00 data 0x55 -> D granted first (m_write=1, m_width=00). After d_ack, D drops req, then I is granted and gets i_ack.
- Starvation, STARVE_LIMIT=4: i_req held high while d_req is re-raised every IDLE cycle -> 4 consecutive D grants, the 5th grant goes to I, and starve_cnt returns to 0.
- Abort: I granted, fetch drops i_req two cycles before m_ack -> m_req stays 1 until m_ack, no i_ack, arbiter returns to IDLE, and a following d_req is granted normally.
- Reset mid-transaction: reset=1 during BUSY_D -> next cycle state=IDLE, m_req=0, d_ack=0. After reset deasserts, a new d_req completes normally.
- Slow memory: m_ack arrives 5 cycles after m_req -> m_addr, m_wdata and m_width stay stable throughout, busy=1 and grant_d correct, exactly one ack is issued.
